// File: rtl/game_pkg.sv
// Shared game constants: button indices, weapon encoding and the
// direction angle constants in sprite-table order (index 0 = east,
// counter-clockwise increments).
package game_pkg;

    localparam int DIR_BITS_DEFAULT = 4;

    // Button slots inside the debounced button vectors
    localparam int N_BTNS       = 4;
    localparam int BTN_CW       = 0;
    localparam int BTN_CCW      = 1;
    localparam int BTN_WEAPON   = 2;
    localparam int BTN_INTERACT = 3;

    typedef enum logic [1:0] {
        WPN_LASER   = 2'd0,
        WPN_SPREAD  = 2'd1,
        WPN_MISSILE = 2'd2
    } weapon_e;

    // Cardinal angles for the 16-entry sprite table
    localparam logic [3:0] DIR_E = 4'd0;
    localparam logic [3:0] DIR_N = 4'd4;
    localparam logic [3:0] DIR_W = 4'd8;
    localparam logic [3:0] DIR_S = 4'd12;

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: multi-flop synchroniser, stable-level
// debounce counter and a registered single-cycle press pulse.
// btn_n is active-low; level/press are active-high.
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   level_d;
    logic                   synced_lvl;

    assign synced_lvl = ~sync_q[SYNC_STAGES-1];

    // Synchroniser chain; resets to the released (high) level
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
    end

    // Debounce: flip the level only after DEBOUNCE_CYCLES differing samples
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (synced_lvl == level) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            level <= synced_lvl;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered rising-edge detect of the debounced level (press only)
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/ship_ctrl_input.sv
// Spaceship button front end: four debounced buttons, wrap-around
// direction index, cycling weapon index and an interaction pulse.
// Optional auto-repeat of held rotate buttons: define AUTO_REPEAT_EN.
module ship_ctrl_input
    import game_pkg::*;
#(
    parameter int DIR_BITS        = DIR_BITS_DEFAULT,
    parameter int N_WEAPONS       = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12587500,
    parameter int REPEAT_PERIOD   = 2517500
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         Rotate_CW,
    input  logic                         Rotate_CCW,
    input  logic                         Weapon_switch,
    input  logic                         Interaction,
    input  logic                         enable,
    output logic [DIR_BITS-1:0]          dir_state,
    output logic [$clog2(N_WEAPONS)-1:0] weapon_sel,
    output logic                         dir_changed,
    output logic                         weapon_changed,
    output logic                         interact_pulse
);

    localparam int WPN_W = $clog2(N_WEAPONS);
    localparam logic [WPN_W-1:0] WPN_LAST = WPN_W'(N_WEAPONS - 1);

    logic [N_BTNS-1:0]   raw_n;
    logic [N_BTNS-1:0]   btn_level;
    logic [N_BTNS-1:0]   btn_press;
    logic                cw_ev, ccw_ev, wpn_ev;
    logic                rep_up, rep_dn;
    logic                step_up, step_dn;
    logic [DIR_BITS-1:0] dir_next;

    assign raw_n[BTN_CW]       = Rotate_CW;
    assign raw_n[BTN_CCW]      = Rotate_CCW;
    assign raw_n[BTN_WEAPON]   = Weapon_switch;
    assign raw_n[BTN_INTERACT] = Interaction;

    for (genvar i = 0; i < N_BTNS; i++) begin : g_btn
        btn_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .CLK  (CLK),
            .RESET(RESET),
            .btn_n(raw_n[i]),
            .level(btn_level[i]),
            .press(btn_press[i])
        );
    end

    // Game-state events are dropped (not queued) while disabled
    assign cw_ev  = enable & btn_press[BTN_CW];
    assign ccw_ev = enable & btn_press[BTN_CCW];
    assign wpn_ev = enable & btn_press[BTN_WEAPON];

`ifdef AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [REP_W-1:0] REP_FIRE   = REP_W'(REPEAT_DELAY);
    // Reloading here makes the next fire land REPEAT_PERIOD cycles later
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_hold, rep_fire;
    logic             unused_levels;

    assign rep_hold      = enable & (btn_level[BTN_CW] ^ btn_level[BTN_CCW]);
    assign rep_fire      = rep_hold & (rep_cnt == REP_FIRE);
    assign rep_up        = rep_fire & btn_level[BTN_CCW];
    assign rep_dn        = rep_fire & btn_level[BTN_CW];
    assign unused_levels = btn_level[BTN_WEAPON] ^ btn_level[BTN_INTERACT];

    // Repeat timer: armed by a rotate press, runs only while exactly one rotate button is held
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)               rep_cnt <= '0;
        else if (!rep_hold)       rep_cnt <= '0;
        else if (cw_ev | ccw_ev)  rep_cnt <= REP_W'(1);
        else if (rep_fire)        rep_cnt <= REP_RELOAD;
        else if (rep_cnt != '0)   rep_cnt <= rep_cnt + REP_W'(1);
    end
`else
    localparam int unused_rep_params = REPEAT_DELAY + REPEAT_PERIOD;
    logic unused_levels;

    assign rep_up        = 1'b0;
    assign rep_dn        = 1'b0;
    assign unused_levels = ^btn_level;
`endif

    // Opposite steps in the same cycle cancel out
    assign step_up = (ccw_ev & ~cw_ev) | rep_up;
    assign step_dn = (cw_ev & ~ccw_ev) | rep_dn;

    // Next direction with natural modulo-2**DIR_BITS wrap
    always_comb begin
        dir_next = dir_state;
        if (step_up && !step_dn)      dir_next = dir_state + DIR_BITS'(1);
        else if (step_dn && !step_up) dir_next = dir_state - DIR_BITS'(1);
    end

    // Registered direction/weapon state and their change pulses
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            dir_state      <= '0;
            weapon_sel     <= '0;
            dir_changed    <= 1'b0;
            weapon_changed <= 1'b0;
            interact_pulse <= 1'b0;
        end else begin
            dir_state      <= dir_next;
            dir_changed    <= step_up ^ step_dn;
            weapon_changed <= wpn_ev;
            interact_pulse <= btn_press[BTN_INTERACT];
            if (wpn_ev) begin
                weapon_sel <= (weapon_sel == WPN_LAST) ? '0 : weapon_sel + WPN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ship_ctrl_input.sv
// Directed bench for ship_ctrl_input. Stimulus pushes hand-computed
// expected values and arrival cycles into queues; a negedge monitor
// pops them whenever a change/interaction pulse appears.
module tb_ship_ctrl_input;

    // Raw press driven before edge 0 lands on edge SYNC+DEB+1; the bench
    // samples on the following negedge, one more posedge count later.
    localparam int LAT = 2 + 4 + 2;

    localparam int IDX_CW  = 0;
    localparam int IDX_CCW = 1;
    localparam int IDX_WPN = 2;
    localparam int IDX_INT = 3;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       Rotate_CW = 1'b1;
    logic       Rotate_CCW = 1'b1;
    logic       Weapon_switch = 1'b1;
    logic       Interaction = 1'b1;
    logic       enable = 1'b1;
    logic [3:0] dir_state;
    logic [1:0] weapon_sel;
    logic       dir_changed;
    logic       weapon_changed;
    logic       interact_pulse;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic [3:0] exp_dir_q[$];
    int         exp_dir_cyc_q[$];
    logic [1:0] exp_wpn_q[$];
    int         exp_wpn_cyc_q[$];
    int         exp_int_cyc_q[$];

    logic [3:0] m_dir;
    logic [1:0] m_wpn;
    int         m_cyc;

    ship_ctrl_input #(
        .DIR_BITS       (4),
        .N_WEAPONS      (3),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .Rotate_CW     (Rotate_CW),
        .Rotate_CCW    (Rotate_CCW),
        .Weapon_switch (Weapon_switch),
        .Interaction   (Interaction),
        .enable        (enable),
        .dir_state     (dir_state),
        .weapon_sel    (weapon_sel),
        .dir_changed   (dir_changed),
        .weapon_changed(weapon_changed),
        .interact_pulse(interact_pulse)
    );

    // Clock and posedge counter
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int required);
        n_checks++;
        if (actual != required) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic set_btn(input int idx, input logic val);
        case (idx)
            IDX_CW:  Rotate_CW = val;
            IDX_CCW: Rotate_CCW = val;
            IDX_WPN: Weapon_switch = val;
            default: Interaction = val;
        endcase
    endtask

    // Press a button for `hold` cycles, optionally expecting one event with value exp_val
    task automatic press_btn(input int idx, input int hold, input bit expect_evt, input int exp_val);
        @(negedge CLK);
        if (expect_evt) begin
            case (idx)
                IDX_CW, IDX_CCW: begin
                    exp_dir_q.push_back(4'(exp_val));
                    exp_dir_cyc_q.push_back(cyc + LAT);
                end
                IDX_WPN: begin
                    exp_wpn_q.push_back(2'(exp_val));
                    exp_wpn_cyc_q.push_back(cyc + LAT);
                end
                default: exp_int_cyc_q.push_back(cyc + LAT);
            endcase
        end
        set_btn(idx, 1'b0);
        repeat (hold) @(negedge CLK);
        set_btn(idx, 1'b1);
        repeat (12) @(negedge CLK);
    endtask

    // Monitor: every pulse must match the head of its expected queue
    always @(negedge CLK) begin
        if (RESET) begin
            if (dir_changed) begin
                n_checks++;
                if (exp_dir_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dir_unexpected: pulse at cycle %0d dir_state %0d, required none", cyc, dir_state);
                end else begin
                    m_dir = exp_dir_q.pop_front();
                    m_cyc = exp_dir_cyc_q.pop_front();
                    if (dir_state !== m_dir || cyc != m_cyc) begin
                        n_fail++;
                        $display("FAIL dir_event: got dir %0d at cycle %0d, required dir %0d at cycle %0d",
                                 dir_state, cyc, m_dir, m_cyc);
                    end
                end
            end
            if (weapon_changed) begin
                n_checks++;
                if (exp_wpn_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wpn_unexpected: pulse at cycle %0d weapon_sel %0d, required none", cyc, weapon_sel);
                end else begin
                    m_wpn = exp_wpn_q.pop_front();
                    m_cyc = exp_wpn_cyc_q.pop_front();
                    if (weapon_sel !== m_wpn || cyc != m_cyc) begin
                        n_fail++;
                        $display("FAIL wpn_event: got weapon %0d at cycle %0d, required weapon %0d at cycle %0d",
                                 weapon_sel, cyc, m_wpn, m_cyc);
                    end
                end
            end
            if (interact_pulse) begin
                n_checks++;
                if (exp_int_cyc_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL int_unexpected: pulse at cycle %0d, required none", cyc);
                end else begin
                    m_cyc = exp_int_cyc_q.pop_front();
                    if (cyc != m_cyc) begin
                        n_fail++;
                        $display("FAIL int_event: got cycle %0d, required cycle %0d", cyc, m_cyc);
                    end
                end
            end
        end
    end

    initial begin
        // Reset
        repeat (3) @(negedge CLK);
        check("reset_dir", int'(dir_state), 0);
        check("reset_wpn", int'(weapon_sel), 0);
        check("reset_pulses", int'({dir_changed, weapon_changed, interact_pulse}), 0);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        check("idle_dir", int'(dir_state), 0);

        // CCW held 10 cycles: one step to 1 on edge 7, nothing more
        press_btn(IDX_CCW, 10, 1'b1, 1);
        check("ccw_hold_dir", int'(dir_state), 1);

        // Wrap both ways: 1 -> 0 -> 15 -> 0
        press_btn(IDX_CW, 6, 1'b1, 0);
        press_btn(IDX_CW, 6, 1'b1, 15);
        check("cw_wrap_dir", int'(dir_state), 15);
        press_btn(IDX_CCW, 6, 1'b1, 0);

        // Glitches of 3 cycles with 3-cycle gaps: no event
        @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            Rotate_CCW = 1'b0;
            repeat (3) @(negedge CLK);
            Rotate_CCW = 1'b1;
            repeat (3) @(negedge CLK);
        end
        repeat (12) @(negedge CLK);
        check("glitch_dir", int'(dir_state), 0);

        // CW and CCW together: cancel
        @(negedge CLK);
        Rotate_CW  = 1'b0;
        Rotate_CCW = 1'b0;
        repeat (10) @(negedge CLK);
        Rotate_CW  = 1'b1;
        Rotate_CCW = 1'b1;
        repeat (12) @(negedge CLK);
        check("cancel_dir", int'(dir_state), 0);

        // Weapon cycling 1, 2, 0
        press_btn(IDX_WPN, 6, 1'b1, 1);
        press_btn(IDX_WPN, 6, 1'b1, 2);
        press_btn(IDX_WPN, 6, 1'b1, 0);

        // Disabled: weapon and rotate dropped, interaction still pulses
        enable = 1'b0;
        press_btn(IDX_WPN, 6, 1'b0, 0);
        press_btn(IDX_CCW, 6, 1'b0, 0);
        press_btn(IDX_INT, 6, 1'b1, 0);
        check("disabled_wpn", int'(weapon_sel), 0);
        check("disabled_dir", int'(dir_state), 0);
        enable = 1'b1;

        // Enabled again
        press_btn(IDX_INT, 6, 1'b1, 0);
        press_btn(IDX_CCW, 6, 1'b1, 1);
        press_btn(IDX_WPN, 6, 1'b1, 1);
        check("final_dir", int'(dir_state), 1);

`ifdef AUTO_REPEAT_EN
        // Clean start, then hold CCW: steps at +0, +20, +28, +36 from the press event
        @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        exp_dir_q.push_back(4'd1); exp_dir_cyc_q.push_back(cyc + LAT);
        exp_dir_q.push_back(4'd2); exp_dir_cyc_q.push_back(cyc + LAT + 20);
        exp_dir_q.push_back(4'd3); exp_dir_cyc_q.push_back(cyc + LAT + 28);
        exp_dir_q.push_back(4'd4); exp_dir_cyc_q.push_back(cyc + LAT + 36);
        Rotate_CCW = 1'b0;
        repeat (50) @(negedge CLK);
        check("repeat_dir", int'(dir_state), 4);
        // Reset mid-hold clears state at once, no further steps
        RESET = 1'b0;
        Rotate_CCW = 1'b1;
        #1;
        check("repeat_reset_dir", int'(dir_state), 0);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        repeat (30) @(negedge CLK);
        check("repeat_after_reset_dir", int'(dir_state), 0);
`endif

        // Every expected event must have been seen
        check("dir_q_empty", exp_dir_q.size(), 0);
        check("wpn_q_empty", exp_wpn_q.size(), 0);
        check("int_q_empty", exp_int_cyc_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
